// File: rtl/matrix_reg_in.sv
// matrix_reg_in: write-side 5x5 byte-matrix register bank.
// Bytes are written one at a time into a 25-byte shadow buffer, either by
// row/col address or through an auto-incrementing pointer. A commit moves
// the shadow, masked to the active size N, into a 200-bit output register.
// The output register has a valid/ack handshake. The shadow can refill
// while the consumer still holds the previous matrix.
module matrix_reg_in #(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     wr_auto,
  input  logic [5:0]               wr_addr,
  input  logic [W-1:0]             wr_data,
  output logic                     wr_ready,
  input  logic [2:0]               mat_size,
  input  logic                     commit,
  output logic [ROWS*COLS*W-1:0]   mat_out,
  output logic                     mat_valid,
  input  logic                     mat_ack,
  output logic                     busy,
  output logic                     addr_err
);

  localparam int NE = ROWS * COLS;

  typedef enum logic {S_ACCEPT, S_PEND} state_t;

  state_t                r_state;
  logic [NE-1:0][W-1:0]  r_shadow;
  logic [NE-1:0][W-1:0]  r_mat_out;
  logic [2:0]            r_row, r_col;
  logic                  r_mat_valid;
  logic                  r_addr_err;

  logic [NE-1:0][W-1:0]  w_shadow_nx;
  logic [NE-1:0][W-1:0]  w_masked;
  logic [2:0]            w_row_nx, w_col_nx;
  logic [2:0]            w_n;
  logic [5:0]            w_pidx, w_aidx;
  logic                  w_wr, w_auto_commit, w_bad, w_commit, w_free, w_xfer;

  // Sizes 0 and 6..7 fall back to the full 5x5 matrix.
  assign w_n = (mat_size == 3'd0 || mat_size > 3'd5) ? 3'd5 : mat_size;

  assign w_wr   = wr_en && (r_state == S_ACCEPT);
  assign w_pidx = {3'b000, r_row} * 6'd5 + {3'b000, r_col};
  assign w_aidx = {3'b000, wr_addr[5:3]} * 6'd5 + {3'b000, wr_addr[2:0]};

  // Shadow with this cycle's write folded in, plus the next pointer value.
  // Pointer wrap uses >= so a mid-fill size change can never trap it.
  always_comb begin
    w_shadow_nx   = r_shadow;
    w_row_nx      = r_row;
    w_col_nx      = r_col;
    w_auto_commit = 1'b0;
    w_bad         = 1'b0;
    if (w_wr) begin
      if (wr_auto) begin
        if (w_pidx < 6'(NE)) w_shadow_nx[w_pidx[4:0]] = wr_data;
        if (r_col >= w_n - 3'd1) begin
          w_col_nx = 3'd0;
          if (r_row >= w_n - 3'd1) begin
            w_row_nx      = 3'd0;
            w_auto_commit = 1'b1;
          end else begin
            w_row_nx = r_row + 3'd1;
          end
        end else begin
          w_col_nx = r_col + 3'd1;
        end
      end else if (wr_addr[5:3] <= 3'd4 && wr_addr[2:0] <= 3'd4) begin
        w_shadow_nx[w_aidx[4:0]] = wr_data;
      end else begin
        w_bad = 1'b1;
      end
    end
  end

  // Zero every element outside the active N x N window.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign w_masked[r*COLS+c] = (3'(r) < w_n && 3'(c) < w_n) ?
                                  w_shadow_nx[r*COLS+c] : '0;
    end
  end

  assign w_free   = !r_mat_valid || mat_ack;
  assign w_commit = (r_state == S_ACCEPT) && (commit || w_auto_commit);
  assign w_xfer   = w_free && (w_commit || r_state == S_PEND);

  // Control FSM, shadow buffer and output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_ACCEPT;
      r_shadow    <= '0;
      r_mat_out   <= '0;
      r_mat_valid <= 1'b0;
      r_addr_err  <= 1'b0;
      r_row       <= 3'd0;
      r_col       <= 3'd0;
    end else begin
      r_addr_err <= w_bad;
      if (w_xfer) begin
        r_mat_out   <= w_masked;
        r_mat_valid <= 1'b1;
        r_shadow    <= '0;
        r_row       <= 3'd0;
        r_col       <= 3'd0;
        r_state     <= S_ACCEPT;
      end else begin
        r_shadow <= w_shadow_nx;
        r_row    <= w_row_nx;
        r_col    <= w_col_nx;
        if (w_commit) r_state <= S_PEND;
        if (mat_ack) r_mat_valid <= 1'b0;
      end
    end
  end

  assign wr_ready  = (r_state == S_ACCEPT);
  assign busy      = (r_state == S_PEND);
  assign mat_out   = r_mat_out;
  assign mat_valid = r_mat_valid;
  assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_matrix_reg_in.sv
// tb_matrix_reg_in: directed plan scenarios followed by random traffic.
// An array-based reference model predicts each published matrix into a
// queue; a negedge monitor pops and compares whenever a new matrix appears.
module tb_matrix_reg_in;

  logic         clk = 1'b0;
  logic         rst, wr_en, wr_auto, commit, mat_ack;
  logic [5:0]   wr_addr;
  logic [7:0]   wr_data;
  logic [2:0]   mat_size;
  logic         wr_ready, mat_valid, busy, addr_err;
  logic [199:0] mat_out;

  int checks = 0;
  int errors = 0;

  matrix_reg_in dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_auto(wr_auto),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mat_size(mat_size), .commit(commit), .mat_out(mat_out),
    .mat_valid(mat_valid), .mat_ack(mat_ack), .busy(busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]   m [25];
  int           pr, pc;
  bit           pend, mvalid, exp_err;
  logic [199:0] q [$];

  task automatic model(input bit r, en, au, input logic [5:0] a,
                       input logic [7:0] d, input logic [2:0] ms,
                       input bit cm, ak);
    int n;
    bit free, ac, xfer;
    int row, col;
    logic [199:0] e;
    n = (ms == 0 || ms > 5) ? 5 : int'(ms);
    ac = 0; xfer = 0; exp_err = 0;
    if (!r) begin
      foreach (m[i]) m[i] = 8'h00;
      pr = 0; pc = 0; pend = 0; mvalid = 0;
      return;
    end
    free = !mvalid || ak;
    if (!pend) begin
      if (en) begin
        if (au) begin
          m[pr*5+pc] = d;
          if (pc == n-1) begin
            pc = 0;
            if (pr == n-1) begin pr = 0; ac = 1; end
            else pr++;
          end else pc++;
        end else begin
          row = int'(a[5:3]); col = int'(a[2:0]);
          if (row <= 4 && col <= 4) m[row*5+col] = d;
          else exp_err = 1;
        end
      end
      if (cm || ac) begin
        if (free) xfer = 1;
        else pend = 1;
      end
    end else if (free) begin
      xfer = 1; pend = 0;
    end
    if (xfer) begin
      for (int i = 0; i < 25; i++)
        e[8*i +: 8] = ((i/5) < n && (i%5) < n) ? m[i] : 8'h00;
      q.push_back(e);
      foreach (m[i]) m[i] = 8'h00;
      pr = 0; pc = 0; mvalid = 1;
    end else if (ak) begin
      mvalid = 0;
    end
  endtask

  // One clock: drive, predict, step, then check the status outputs.
  task automatic cyc(input bit r, en, au, input logic [5:0] a,
                     input logic [7:0] d, input logic [2:0] ms,
                     input bit cm, ak);
    rst = r; wr_en = en; wr_auto = au; wr_addr = a; wr_data = d;
    mat_size = ms; commit = cm; mat_ack = ak;
    model(r, en, au, a, d, ms, cm, ak);
    @(posedge clk); #1;
    checks++;
    if (busy !== pend || wr_ready !== !pend || addr_err !== exp_err) begin
      errors++;
      $display("FAIL status t=%0t busy=%b wr_ready=%b addr_err=%b required busy=%b wr_ready=%b addr_err=%b",
               $time, busy, wr_ready, addr_err, pend, !pend, exp_err);
    end
  endtask

  task automatic idle(input logic [2:0] ms, input bit ak);
    cyc(1, 0, 0, 6'd0, 8'd0, ms, 0, ak);
  endtask

  // Monitor: a new matrix is presented after any edge where valid rose or
  // the held matrix was acknowledged while another took its place.
  bit last_v, last_a;
  always @(negedge clk) begin
    if (mat_valid === 1'b1 && (!last_v || last_a)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_matrix t=%0t mat_out=%h required none", $time, mat_out);
      end else begin
        logic [199:0] e;
        e = q.pop_front();
        if (mat_out !== e) begin
          errors++;
          $display("FAIL mat_out t=%0t got %h required %h", $time, mat_out, e);
        end
      end
    end
    last_v = (mat_valid === 1'b1);
    last_a = (mat_ack === 1'b1);
  end

  initial begin
    pr = 0; pc = 0; pend = 0; mvalid = 0;
    foreach (m[i]) m[i] = 8'h00;
    cyc(0, 0, 0, 6'd0, 8'd0, 3'd5, 0, 0);
    cyc(0, 0, 0, 6'd0, 8'd0, 3'd5, 0, 0);
    checks++;
    if (mat_out !== '0 || mat_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset mat_out=%h mat_valid=%b required 0 0", mat_out, mat_valid);
    end

    // N=5 auto fill 1..25, the 25th write auto-commits
    for (int i = 1; i <= 25; i++) cyc(1, 1, 1, 6'd0, 8'(i), 3'd5, 0, 0);
    idle(3'd5, 1);

    // N=3 auto fill A0..A8
    for (int i = 0; i < 9; i++) cyc(1, 1, 1, 6'd0, 8'hA0 + 8'(i), 3'd3, 0, 0);
    idle(3'd3, 1);

    // Out-of-range row, then a corner write published by explicit commit
    cyc(1, 1, 0, 6'b101_000, 8'hEE, 3'd5, 0, 0);
    idle(3'd5, 0);
    cyc(1, 1, 0, 6'b100_100, 8'h5C, 3'd5, 0, 0);
    cyc(1, 0, 0, 6'd0, 8'd0, 3'd5, 1, 0);

    // Commit against a held matrix: PEND, writes ignored, ack releases it
    cyc(1, 1, 0, 6'b000_001, 8'h77, 3'd5, 0, 0);
    cyc(1, 0, 0, 6'd0, 8'd0, 3'd5, 1, 0);
    cyc(1, 1, 0, 6'b000_010, 8'h99, 3'd5, 0, 0);
    cyc(1, 1, 1, 6'd0, 8'h98, 3'd5, 1, 0);
    idle(3'd5, 1);
    idle(3'd5, 1);

    // Write and commit in the same cycle with the slot free
    cyc(1, 1, 0, 6'b000_000, 8'h11, 3'd5, 1, 0);
    idle(3'd5, 1);

    // Reset while pending with partial data, then commit an empty buffer
    cyc(1, 0, 0, 6'd0, 8'd0, 3'd5, 1, 0);
    cyc(1, 1, 0, 6'b011_011, 8'h42, 3'd5, 0, 0);
    cyc(1, 0, 0, 6'd0, 8'd0, 3'd5, 1, 0);
    cyc(0, 0, 0, 6'd0, 8'd0, 3'd5, 0, 0);
    checks++;
    if (mat_out !== '0 || mat_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_pend mat_out=%h mat_valid=%b required 0 0", mat_out, mat_valid);
    end
    cyc(1, 0, 0, 6'd0, 8'd0, 3'd5, 1, 0);
    idle(3'd5, 1);

    // Random traffic; size only changes while the pointer is at (0,0)
    begin
      logic [2:0] ms;
      logic [5:0] a;
      ms = 3'd5;
      for (int k = 0; k < 1500; k++) begin
        if (pr == 0 && pc == 0 && $urandom_range(0, 7) == 0) ms = 3'($urandom_range(0, 7));
        a = ($urandom_range(0, 3) == 0) ? 6'($urandom) :
            {3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))};
        cyc($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0, a, 8'($urandom), ms,
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
      end
    end

    idle(3'd5, 1);
    idle(3'd5, 1);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_matrices got %0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
